// File: rtl/hough_vote_sequencer.sv
// Hough voting engine: buffers one binary edge frame, clears the (theta,rho) accumulator,
// then read-modify-writes one vote per edge pixel and theta using rho from an external trig unit.
module hough_vote_sequencer #(
    parameter  int IMG_W      = 640,
    parameter  int IMG_H      = 480,
    parameter  int BEAT_W     = 240,
    parameter  int N_THETA    = 181,
    parameter  int RHO_OFFSET = 800,
    parameter  int RHO_W      = 11,
    parameter  int ACC_W      = 16,
    localparam int N_RHO      = 2*RHO_OFFSET+1,
    localparam int NB         = IMG_W*IMG_H/BEAT_W,
    localparam int XW         = $clog2(IMG_W),
    localparam int YW         = $clog2(IMG_H),
    localparam int TW         = $clog2(N_THETA),
    localparam int AW         = $clog2(N_THETA*N_RHO)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    output logic [XW-1:0]     x_out,
    output logic [YW-1:0]     y_out,
    output logic [TW-1:0]     theta_out,
    input  logic [RHO_W-1:0]  rho_in,
    output logic [AW-1:0]     acc_addr,
    output logic              acc_we,
    output logic [ACC_W-1:0]  acc_wdata,
    input  logic [ACC_W-1:0]  acc_rdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       vote_count,
    output logic [31:0]       drop_count
);
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
    localparam int BTW = (BEAT_W > 1) ? $clog2(BEAT_W) : 1;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LOAD  = 4'd1;
    localparam logic [3:0] S_CLEAR = 4'd2;
    localparam logic [3:0] S_SCAN  = 4'd3;
    localparam logic [3:0] S_TEST  = 4'd4;
    localparam logic [3:0] S_CALC  = 4'd5;
    localparam logic [3:0] S_READ  = 4'd6;
    localparam logic [3:0] S_WRITE = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam logic [XW-1:0]        X_LAST   = XW'(IMG_W-1);
    localparam logic [YW-1:0]        Y_LAST   = YW'(IMG_H-1);
    localparam logic [TW-1:0]        T_LAST   = TW'(N_THETA-1);
    localparam logic [BIW-1:0]       B_LAST   = BIW'(NB-1);
    localparam logic [BTW-1:0]       BIT_LAST = BTW'(BEAT_W-1);
    localparam logic [AW-1:0]        ACC_LAST = AW'(N_THETA*N_RHO-1);
    localparam logic [AW-1:0]        NRHO_A   = AW'(N_RHO);
    localparam logic signed [RHO_W:0] OFF_S   = (RHO_W+1)'(RHO_OFFSET);
    localparam logic signed [RHO_W:0] NRHO_S  = (RHO_W+1)'(N_RHO);

    logic [3:0]        r_state;
    logic [BEAT_W-1:0] r_mem [NB];
    logic [BEAT_W-1:0] r_rd_word;
    logic [BIW-1:0]    r_beat;
    logic [BIW-1:0]    r_word;
    logic [BTW-1:0]    r_bit;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [TW-1:0]     r_theta;
    logic [AW-1:0]     r_acc_addr;
    logic [31:0]       r_votes;
    logic [31:0]       r_drops;

    logic              w_accept;
    logic [BIW-1:0]    w_wr_idx;
    logic signed [RHO_W:0] w_idx;
    logic              w_idx_ok;
    logic [AW-1:0]     w_vote_addr;
    logic [ACC_W-1:0]  w_sat;
    logic              w_theta_adv;
    logic              w_pix_adv;
    logic              w_pix_last;

    assign in_ready    = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_accept    = in_valid && in_ready;
    assign w_wr_idx    = (r_state == S_IDLE) ? '0 : r_beat;
    assign w_idx       = $signed({rho_in[RHO_W-1], rho_in}) + OFF_S;
    assign w_idx_ok    = !w_idx[RHO_W] && (w_idx < NRHO_S);
    assign w_vote_addr = AW'(r_theta) * NRHO_A + AW'(w_idx[RHO_W-1:0]);
    assign w_sat       = (acc_rdata == '1) ? acc_rdata : acc_rdata + ACC_W'(1);
    assign w_pix_last  = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_theta_adv = ((r_state == S_READ) && !w_idx_ok) || (r_state == S_WRITE);
    assign w_pix_adv   = ((r_state == S_TEST) && !r_rd_word[r_bit]) ||
                         (w_theta_adv && (r_theta == T_LAST));

    // The vote address is presented combinationally in READ so the 1-cycle RAM read lands in WRITE.
    assign acc_addr   = (r_state == S_READ) ? w_vote_addr : r_acc_addr;
    assign acc_we     = (r_state == S_CLEAR) || (r_state == S_WRITE);
    assign acc_wdata  = (r_state == S_WRITE) ? w_sat : '0;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign theta_out  = r_theta;
    assign vote_count = r_votes;
    assign drop_count = r_drops;

    always_ff @(posedge clock) begin
        if (w_accept) r_mem[w_wr_idx] <= in_data;
        if (r_state == S_SCAN) r_rd_word <= r_mem[r_word];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_word     <= '0;
            r_bit      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_theta    <= '0;
            r_acc_addr <= '0;
            r_votes    <= '0;
            r_drops    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_votes <= '0;
                    r_drops <= '0;
                    r_beat  <= BIW'(1);
                    if (NB == 1) begin
                        r_state    <= S_CLEAR;
                        r_acc_addr <= '0;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: if (w_accept) begin
                    r_beat <= r_beat + BIW'(1);
                    if (r_beat == B_LAST) begin
                        r_state    <= S_CLEAR;
                        r_acc_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_acc_addr == ACC_LAST) begin
                        r_state <= S_SCAN;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_word  <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_acc_addr <= r_acc_addr + AW'(1);
                    end
                end
                S_SCAN: r_state <= S_TEST;
                S_TEST: if (r_rd_word[r_bit]) begin
                    r_theta <= '0;
                    r_state <= S_CALC;
                end
                S_CALC: r_state <= S_READ;
                S_READ: begin
                    if (w_idx_ok) begin
                        r_acc_addr <= w_vote_addr;
                        r_state    <= S_WRITE;
                    end else begin
                        r_drops <= r_drops + 32'd1;
                    end
                end
                S_WRITE: r_votes <= r_votes + 32'd1;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Theta/pixel stepping shared by TEST, READ (drop) and WRITE; overrides the case above.
            if (w_theta_adv && (r_theta != T_LAST)) begin
                r_theta <= r_theta + TW'(1);
                r_state <= S_CALC;
            end
            if (w_pix_adv) begin
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= w_pix_last ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
                if (r_bit == BIT_LAST) begin
                    r_bit  <= '0;
                    r_word <= r_word + BIW'(1);
                end else begin
                    r_bit <= r_bit + BTW'(1);
                end
                r_state <= w_pix_last ? S_DONE : S_SCAN;
            end
        end
    end
endmodule

// File: tb/tb_hough_vote_sequencer.sv
// Scoreboard bench for hough_vote_sequencer on an 8x4 frame with 4 thetas and a behavioural
// accumulator RAM and trig unit.
module tb_hough_vote_sequencer;
    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic [2:0]         x_out;
    logic [1:0]         y_out;
    logic [1:0]         theta_out;
    logic signed [10:0] rho_in = '0;
    logic [6:0]         acc_addr;
    logic               acc_we;
    logic [15:0]        acc_wdata;
    logic [15:0]        acc_rdata;
    logic               busy;
    logic               done;
    logic [31:0]        vote_count;
    logic [31:0]        drop_count;

    hough_vote_sequencer #(
        .IMG_W(8), .IMG_H(4), .BEAT_W(8), .N_THETA(4),
        .RHO_OFFSET(10), .RHO_W(11), .ACC_W(16)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .x_out(x_out), .y_out(y_out), .theta_out(theta_out), .rho_in(rho_in),
        .acc_addr(acc_addr), .acc_we(acc_we), .acc_wdata(acc_wdata), .acc_rdata(acc_rdata),
        .busy(busy), .done(done), .vote_count(vote_count), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct { int addr; int data; } wr_t;
    wr_t  sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   scan_cyc = 0;
    int   mode = 0;
    bit   force_ff = 1'b0;
    logic [15:0] ram [0:127];
    logic [15:0] ram_q = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Trig-unit model: mode 0 gives rho = theta-2, mode 1 drives out-of-range rho on thetas 0 and 1.
    function automatic int rho_model(input int t);
        if (mode == 0) return t - 2;
        if (t == 0) return 11;
        if (t == 1) return -11;
        return 0;
    endfunction

    always @(posedge clock) begin
        rho_in <= 11'(rho_model(int'(theta_out)));
        ram_q  <= ram[acc_addr];
        if (acc_we) ram[acc_addr] <= acc_wdata;
    end
    assign acc_rdata = force_ff ? 16'hFFFF : ram_q;

    always @(negedge clock) begin
        if (busy && !in_ready && !acc_we && !done) scan_cyc++;
        if (acc_we) begin
            if (sb.size() == 0) begin
                chk("acc_we_extra", 32'(acc_we), 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("acc_addr", 32'(acc_addr), e.addr);
                chk("acc_wdata", 32'(acc_wdata), e.data);
                if (e.data != 0) begin
                    chk("vote_x", 32'(x_out), 32'd3);
                    chk("vote_y", 32'(y_out), 32'd2);
                    chk("vote_theta", 32'(theta_out), e.addr / 21);
                end
            end
        end
    end

    // Expected writes for one frame: full clear, then votes for an edge at pixel (3,2) if present.
    task automatic prepare(input bit edge_px, output int ev, output int ed);
        wr_t w;
        ev = 0;
        ed = 0;
        for (int unsigned a = 0; a < 84; a++) begin
            w.addr = int'(a);
            w.data = 0;
            sb.push_back(w);
        end
        if (edge_px) begin
            for (int t = 0; t < 4; t++) begin
                int idx;
                idx = rho_model(t) + 10;
                if (idx >= 0 && idx < 21) begin
                    w.addr = t * 21 + idx;
                    w.data = force_ff ? 32'hFFFF : 1;
                    sb.push_back(w);
                    ev++;
                end else begin
                    ed++;
                end
            end
        end
    endtask

    task automatic send_beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int unsigned i = 0; i < 400 && !in_ready; i++) @(negedge clock);
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b2);
        send_beat(8'h00);
        send_beat(8'h00);
        send_beat(b2);
        send_beat(8'h00);
    endtask

    task automatic wait_done(input int ev, input int ed, input int escan);
        for (int unsigned i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (done) break;
        end
        chk("done", 32'(done), 32'd1);
        chk("vote_count", vote_count, ev);
        chk("drop_count", drop_count, ed);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("scan_cycles", scan_cyc, escan);
        @(negedge clock);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        scan_cyc = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_acc_we"}, 32'(acc_we), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ev;
        int ed;
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (2) @(negedge clock);
        #1;
        check_reset_state("rst");
        chk("rst_vote", vote_count, 32'd0);
        chk("rst_drop", drop_count, 32'd0);
        chk("rst_xyt", {27'd0, x_out, y_out, theta_out}, 32'd0);
        chk("rst_addr", 32'(acc_addr), 32'd0);
        chk("rst_wdata", 32'(acc_wdata), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        scan_cyc = 0;

        // Zero frame with in_valid gaps during LOAD
        prepare(1'b0, ev, ed);
        send_beat(8'h00);
        repeat (2) @(negedge clock);
        send_beat(8'h00);
        @(negedge clock);
        send_beat(8'h00);
        repeat (3) @(negedge clock);
        send_beat(8'h00);
        wait_done(ev, ed, 64);

        // Single edge pixel; next frame's first beat is held during CLEAR
        mode = 0;
        prepare(1'b1, ev, ed);
        send_frame(8'h08);
        in_valid = 1'b1;
        in_data  = 8'h00;
        repeat (5) begin
            @(negedge clock);
            chk("in_ready_clear", 32'(in_ready), 32'd0);
        end
        wait_done(ev, ed, 72);

        // Held beat is accepted now; out-of-range rho frame
        mode = 1;
        prepare(1'b1, ev, ed);
        chk("held_valid", 32'(in_ready & in_valid), 32'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        send_beat(8'h00);
        send_beat(8'h08);
        send_beat(8'h00);
        wait_done(ev, ed, 72);

        // Saturating accumulator
        mode = 0;
        force_ff = 1'b1;
        prepare(1'b1, ev, ed);
        send_frame(8'h08);
        wait_done(ev, ed, 72);
        force_ff = 1'b0;

        // Reset mid-CLEAR
        prepare(1'b0, ev, ed);
        send_frame(8'h00);
        repeat (10) @(negedge clock);
        chk("in_clear", 32'(acc_we), 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_state("rst_clear");
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        scan_cyc = 0;

        // Reset mid-WRITE
        prepare(1'b1, ev, ed);
        send_frame(8'h08);
        for (int unsigned i = 0; i < 400; i++) begin
            @(negedge clock);
            if (acc_we && acc_wdata != 16'h0) break;
        end
        chk("write_seen", 32'(acc_we), 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_state("rst_write");
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        scan_cyc = 0;

        // Normal frame after abort
        prepare(1'b1, ev, ed);
        send_frame(8'h08);
        wait_done(ev, ed, 72);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
